// File: rtl/rover_locator.sv
// rover_locator: reduces a stream of ultrasound echo samples to one filtered
// polar fix per sweep, {angle, distance}, with a new_data flag that is held
// until a vsync pulse has passed so the VGA writer can latch it in blanking.
// Optional feature: define LOCATOR_AVERAGE_EN to smooth accepted distances
// by averaging with the previous fix.
module rover_locator #(
  parameter int NUM_ANGLES     = 12,
  parameter int MIN_VALID_DIST = 4,
  parameter int MAX_JUMP       = 32,
  parameter int MAX_MISSES     = 3
) (
  input  logic        vclock,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic [3:0]  sample_angle,
  input  logic [7:0]  sample_distance,
  input  logic        sweep_done,
  input  logic        vsync,
  output logic [11:0] location,
  output logic        new_data,
  output logic        fix_valid,
  output logic        lost
);

  localparam int MW = $clog2(MAX_MISSES + 1);

  localparam logic [4:0]    ANGLE_LIMIT = 5'(NUM_ANGLES);
  localparam logic [7:0]    MIN_DIST    = 8'(MIN_VALID_DIST);
  localparam logic [8:0]    JUMP_LIMIT  = 9'(MAX_JUMP);
  localparam logic [MW-1:0] MISS_SAT    = MW'(MAX_MISSES);
  localparam logic [7:0]    NO_ECHO     = 8'hFF;

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] EVAL  = 1'b1;

  logic [0:0]    state;
  logic [7:0]    best_dist;
  logic [3:0]    best_angle;
  logic          found;
  logic [7:0]    cand_dist;
  logic [3:0]    cand_angle;
  logic          cand_found;
  logic [MW-1:0] miss_count;
  logic          vsync_prev;

  logic          qualified;
  logic          take_sample;
  logic          sweep_close;
  logic [8:0]    jump;
  logic [8:0]    jump_abs;
  logic          at_sat;
  logic          accept;
  logic [MW-1:0] miss_next;
  logic [7:0]    accepted_dist;
  logic          vsync_rise;

  // Sample qualification and best-echo comparison (strict less-than keeps the earlier tie).
  always_comb begin
    qualified   = sample_valid
                && ({1'b0, sample_angle} < ANGLE_LIMIT)
                && (sample_distance >= MIN_DIST)
                && (sample_distance != NO_ECHO);
    take_sample = qualified && (sample_distance < best_dist);
    sweep_close = (state == ACCUM) && sweep_done;
  end

  // Track nearest echo; on sweep close hand the result (including a same-cycle sample) to the candidate.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      best_dist  <= NO_ECHO;
      best_angle <= 4'd0;
      found      <= 1'b0;
      cand_dist  <= NO_ECHO;
      cand_angle <= 4'd0;
      cand_found <= 1'b0;
    end else if (sweep_close) begin
      cand_dist  <= take_sample ? sample_distance : best_dist;
      cand_angle <= take_sample ? sample_angle    : best_angle;
      cand_found <= found | take_sample;
      best_dist  <= NO_ECHO;
      found      <= 1'b0;
    end else if (take_sample) begin
      best_dist  <= sample_distance;
      best_angle <= sample_angle;
      found      <= 1'b1;
    end
  end

  // Two-state sequencer: one EVAL cycle after each sweep; sweep_done in EVAL is ignored.
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ACCUM;
    end else if (state == EVAL) begin
      state <= ACCUM;
    end else if (sweep_done) begin
      state <= EVAL;
    end
  end

  // Plausibility check of the candidate against the previous fix and miss-count update.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    jump      = {1'b0, cand_dist} - {1'b0, location[7:0]};
    jump_abs  = jump[8] ? (~jump + 9'd1) : jump;
    at_sat    = (miss_count == MISS_SAT);
    accept    = (state == EVAL) && cand_found
                && (!fix_valid || (jump_abs <= JUMP_LIMIT) || at_sat);
    miss_next = miss_count;
    if (accept) begin
      miss_next = '0;
    end else if ((state == EVAL) && !at_sat) begin
      miss_next = miss_count + MW'(1);
    end
    vsync_rise = !vsync_prev && vsync;
  end

`ifdef LOCATOR_AVERAGE_EN
  logic [8:0] dist_sum;

  // Smoothed distance; raw value on the first fix and when the miss override forced acceptance.
  always_comb begin
    dist_sum      = {1'b0, cand_dist} + {1'b0, location[7:0]} + 9'd1;
    accepted_dist = (fix_valid && !at_sat) ? dist_sum[8:1] : cand_dist;
  end
`else
  // Accepted distance is the raw candidate.
  always_comb begin
    accepted_dist = cand_dist;
  end
`endif

  // Registered outputs and the vsync-synchronised new_data handshake (accept beats clear).
  // NOTE: only control/output registers need reset here; no memories are involved.
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      location   <= 12'd0;
      new_data   <= 1'b0;
      fix_valid  <= 1'b0;
      lost       <= 1'b0;
      miss_count <= '0;
      vsync_prev <= 1'b1;
    end else begin
      vsync_prev <= vsync;
      miss_count <= miss_next;
      lost       <= (miss_next == MISS_SAT);
      if (accept) begin
        location  <= {cand_angle, accepted_dist};
        fix_valid <= 1'b1;
        new_data  <= 1'b1;
      end else if (vsync_rise) begin
        new_data  <= 1'b0;
      end
    end
  end

endmodule
